hdmi_tmds_tx: RTL and testbench

//   Upstream feeder for the 4-lane DDR LVDS HDMI output primitive (hdmi_out).

---
 rtl/hdmi_tmds_tx.sv | 170 +++++++++++++++++
 tb/tb_hdmi_tmds_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tmds_tx.sv
// TMDS transmitter front end on the 5x pixel clock: requests one pixel per 5-cycle slot,
// encodes it (DVI 8b/10b or control symbols) and serialises 2 bits per cycle for hdmi_out.
`timescale 1ns/1ps
module hdmi_tmds_tx #(
    parameter logic [3:0] LANE_INV = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_req,
    input  logic       pix_de,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic       pix_hsync,
    input  logic       pix_vsync,
    output logic [7:0] hdmi_data
);

    localparam logic [9:0] CTRL00 = 10'b1101010100;
    localparam logic [9:0] CTRL01 = 10'b0010101011;
    localparam logic [9:0] CTRL10 = 10'b0101010100;
    localparam logic [9:0] CTRL11 = 10'b1010101011;

    localparam logic [7:0] INV_MASK = {{2{LANE_INV[3]}}, {2{LANE_INV[2]}},
                                       {2{LANE_INV[1]}}, {2{LANE_INV[0]}}};

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) sum = sum + {3'b000, v[i]};
        return sum;
    endfunction

    function automatic logic [9:0] ctrlSym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL00;
            2'b01:   s = CTRL01;
            2'b10:   s = CTRL10;
            default: s = CTRL11;
        endcase
        return s;
    endfunction

    // Transition-minimising stage: XNOR chain when the byte is ones-heavy.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1;
        logic       xnorMode;
        logic [8:0] q;
        n1 = popcount8(d);
        xnorMode = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xnorMode ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xnorMode;
        return q;
    endfunction

    // DC-balancing stage: returns {symbol[9:0], updated running disparity[5:0]}.
    function automatic logic [15:0] balance(input logic [8:0] qm, input logic signed [5:0] cnt);
        logic [3:0]        n1q;
        logic signed [5:0] diff;
        logic [9:0]        sym;
        logic signed [5:0] nxt;
        n1q  = popcount8(qm[7:0]);
        diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        if ((cnt == 6'sd0) || (diff == 6'sd0)) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nxt = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 6'sd0) && (diff > 6'sd0)) || ((cnt < 6'sd0) && (diff < 6'sd0))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + (qm[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt - (qm[8] ? 6'sd0 : 6'sd2) + diff;
        end
        return {sym, nxt};
    endfunction

    function automatic logic [1:0] clkPair(input logic [2:0] ph);
        logic [1:0] p;
        case (ph)
            3'd0, 3'd1: p = 2'b11;
            3'd2:       p = 2'b01;
            default:    p = 2'b00;
        endcase
        return p;
    endfunction

    logic [2:0]       phase_q, phase_d;
    logic             run_q;
    logic             pixReq_q, pixReq_d;
    logic             de0_q, de1_q;
    logic [1:0]       ctl0_q, ctl1_q;
    logic [2:0][7:0]  dat_q;
    logic [2:0][8:0]  qm_q, qm_d;
    logic [2:0][9:0]  sym_q, sym_d;
    logic [2:0][5:0]  cnt_q, cnt_d;
    logic [2:0][9:0]  shift_q, shift_d;
    logic [2:0][15:0] balanced;
    logic [7:0]       out_q, out_d;

    // The first edge after reset only arms the counter, so that slot starts at phase 0
    // showing the reset CTRL00 symbol with a normal clock-lane pattern.
    always_comb begin
        phase_d  = 3'd0;
        balanced = '0;
        qm_d     = qm_q;
        sym_d    = sym_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        if (run_q) phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
        pixReq_d = (phase_d == 3'd0);
        for (int ch = 0; ch < 3; ch++) begin
            qm_d[ch]     = minimise(dat_q[ch]);
            balanced[ch] = balance(qm_q[ch], cnt_q[ch]);
            if (de1_q) begin
                sym_d[ch] = balanced[ch][15:6];
                cnt_d[ch] = balanced[ch][5:0];
            end else begin
                sym_d[ch] = (ch == 0) ? ctrlSym(ctl1_q) : CTRL00;
                cnt_d[ch] = 6'd0;
            end
            if (run_q && (phase_q == 3'd4)) shift_d[ch] = sym_q[ch];
            else if (run_q)                 shift_d[ch] = {2'b00, shift_q[ch][9:2]};
        end
        out_d = {shift_d[2][1:0], shift_d[1][1:0], shift_d[0][1:0], clkPair(phase_d)} ^ INV_MASK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= 3'd0;
            run_q    <= 1'b0;
            pixReq_q <= 1'b0;
            de0_q    <= 1'b0;
            ctl0_q   <= 2'b00;
            dat_q    <= '0;
            de1_q    <= 1'b0;
            ctl1_q   <= 2'b00;
            qm_q     <= '0;
            sym_q    <= {3{CTRL00}};
            cnt_q    <= '0;
            shift_q  <= {3{CTRL00}};
            out_q    <= INV_MASK;
        end else begin
            phase_q  <= phase_d;
            run_q    <= 1'b1;
            pixReq_q <= pixReq_d;
            if (pixReq_q) begin
                de0_q  <= pix_de;
                ctl0_q <= {pix_vsync, pix_hsync};
                dat_q  <= {pix_r, pix_g, pix_b};
            end
            if (run_q && (phase_q == 3'd1)) begin
                de1_q  <= de0_q;
                ctl1_q <= ctl0_q;
                qm_q   <= qm_d;
            end
            if (run_q && (phase_q == 3'd2)) begin
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
            shift_q <= shift_d;
            out_q   <= out_d;
        end
    end

    assign pix_req   = pixReq_q;
    assign hdmi_data = out_q;

endmodule

// File: tb/tb_hdmi_tmds_tx.sv
// Scoreboard bench for hdmi_tmds_tx: a slot-level DVI encoder model queues expected symbols,
// a monitor reassembles each serialised slot from both instances and compares.
`timescale 1ns/1ps
module tb_hdmi_tmds_tx;

    localparam int NSLOTS     = 80;
    localparam int NDIR       = 12;
    localparam int RESET_SLOT = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixDe = 1'b0;
    logic       pixHsync = 1'b0;
    logic       pixVsync = 1'b0;
    logic [7:0] pixR = 8'h00;
    logic [7:0] pixG = 8'h00;
    logic [7:0] pixB = 8'h00;
    logic       pixReqA, pixReqB;
    logic [7:0] hdmiA, hdmiB;

    int         testsRun = 0;
    int         testsFailed = 0;
    int         modelCnt [3];
    logic [29:0] expQ [$];
    bit         checkEn = 1'b0;
    bit         atReq = 1'b0;

    always #5 clk = ~clk;

    hdmi_tmds_tx #(.LANE_INV(4'b0000)) dutA (
        .clk(clk), .reset(reset), .pix_req(pixReqA), .pix_de(pixDe),
        .pix_r(pixR), .pix_g(pixG), .pix_b(pixB),
        .pix_hsync(pixHsync), .pix_vsync(pixVsync), .hdmi_data(hdmiA)
    );

    hdmi_tmds_tx #(.LANE_INV(4'b0001)) dutB (
        .clk(clk), .reset(reset), .pix_req(pixReqB), .pix_de(pixDe),
        .pix_r(pixR), .pix_g(pixG), .pix_b(pixB),
        .pix_hsync(pixHsync), .pix_vsync(pixVsync), .hdmi_data(hdmiB)
    );

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] ctrlRef(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Reference encoder: bit i of the minimised byte is the parity of d[i:0],
    // with odd positions flipped in XNOR mode.
    task automatic encodeRef(input logic [7:0] d, input int cntIn,
                             output logic [9:0] sym, output int cntOut);
        int         ones, n1q, n0q;
        logic       xnorMode, q8;
        logic [7:0] qm;
        logic [8:0] m;
        ones = $countones(d);
        xnorMode = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        for (int i = 0; i < 8; i++) begin
            m = (9'h1 << (i + 1)) - 9'h1;
            qm[i] = (^(d & m[7:0])) ^ (xnorMode && (i % 2 == 1));
        end
        q8  = !xnorMode;
        n1q = $countones(qm);
        n0q = 8 - n1q;
        if (cntIn == 0 || n1q == n0q) begin
            sym = {~q8, q8, q8 ? qm : ~qm};
            cntOut = cntIn + (q8 ? (n1q - n0q) : (n0q - n1q));
        end else if ((cntIn > 0 && n1q > n0q) || (cntIn < 0 && n0q > n1q)) begin
            sym = {1'b1, q8, ~qm};
            cntOut = cntIn + (q8 ? 2 : 0) + n0q - n1q;
        end else begin
            sym = {1'b0, q8, qm};
            cntOut = cntIn - (q8 ? 0 : 2) + n1q - n0q;
        end
    endtask

    // Drives one slot's pixel and queues the symbols it must produce in the following slot.
    task automatic applyStimulus(input logic de, input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b, input logic hs, input logic vs);
        logic [9:0] s0, s1, s2;
        int         c;
        pixDe = de; pixR = r; pixG = g; pixB = b; pixHsync = hs; pixVsync = vs;
        if (de) begin
            encodeRef(b, modelCnt[0], s0, c); modelCnt[0] = c;
            encodeRef(g, modelCnt[1], s1, c); modelCnt[1] = c;
            encodeRef(r, modelCnt[2], s2, c); modelCnt[2] = c;
        end else begin
            s0 = ctrlRef({vs, hs});
            s1 = ctrlRef(2'b00);
            s2 = ctrlRef(2'b00);
            modelCnt = '{default: 0};
        end
        expQ.push_back({s2, s1, s0});
    endtask

    task automatic waitReq();
        int n;
        n = 0;
        @(negedge clk);
        while (!pixReqA && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!pixReqA) checkOutput("pix_req wait", {9'b0, pixReqA}, 10'd1);
    endtask

    // Releases reset away from the negedge and returns on the first phase-0 negedge.
    task automatic releaseReset();
        expQ.delete();
        modelCnt = '{default: 0};
        expQ.push_back({ctrlRef(2'b00), ctrlRef(2'b00), ctrlRef(2'b00)});
        @(negedge clk);
        #2 reset = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("first pix_req", {9'b0, pixReqA}, 10'd1);
    endtask

    task automatic midSlotReset();
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid-slot reset hdmi A", {2'b0, hdmiA}, 10'h000);
        checkOutput("mid-slot reset hdmi B", {2'b0, hdmiB}, 10'h003);
        checkOutput("mid-slot reset pix_req", {9'b0, pixReqA}, 10'd0);
        repeat (3) @(negedge clk);
        releaseReset();
    endtask

    // Monitor: collects five 2-bit pairs per lane starting at each phase-0 cycle.
    int          pairIdx = 0;
    logic [39:0] gotA, gotB;
    always @(negedge clk) begin
        logic [29:0] e;
        if (reset || !checkEn) begin
            pairIdx = 0;
        end else begin
            checkOutput("pix_req framing A", {9'b0, pixReqA}, {9'b0, pairIdx == 0});
            checkOutput("pix_req framing B", {9'b0, pixReqB}, {9'b0, pairIdx == 0});
            for (int k = 0; k < 4; k++) begin
                gotA[10*k + 2*pairIdx +: 2] = hdmiA[2*k +: 2];
                gotB[10*k + 2*pairIdx +: 2] = hdmiB[2*k +: 2];
            end
            pairIdx++;
            if (pairIdx == 5) begin
                pairIdx = 0;
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard underflow", 10'd0, 10'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("clock lane A", gotA[9:0], 10'h01F);
                    checkOutput("clock lane B", gotB[9:0], 10'h3E0);
                    for (int k = 1; k < 4; k++) begin
                        checkOutput($sformatf("data lane%0d A", k), gotA[10*k +: 10], e[10*(k-1) +: 10]);
                        checkOutput($sformatf("data lane%0d B", k), gotB[10*k +: 10], e[10*(k-1) +: 10]);
                    end
                end
            end
        end
    end

    logic [26:0] dirTab [NDIR] = '{
        {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
        {1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0},
        {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1},
        {1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1},
        {1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
        {1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
        {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
        {1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0},
        {1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0},
        {1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0},
        {1'b1, 8'hF0, 8'h0F, 8'hF0, 1'b0, 1'b0},
        {1'b1, 8'h0F, 8'hF0, 8'h0F, 1'b1, 1'b1}
    };

    function automatic logic [7:0] randByte();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [26:0] st;
        modelCnt = '{default: 0};
        repeat (3) @(negedge clk);
        checkOutput("reset hdmi A", {2'b0, hdmiA}, 10'h000);
        checkOutput("reset hdmi B", {2'b0, hdmiB}, 10'h003);
        checkOutput("reset pix_req", {9'b0, pixReqA}, 10'd0);
        releaseReset();
        atReq = 1'b1;
        for (int s = 0; s < NSLOTS; s++) begin
            if (!atReq) waitReq();
            atReq = 1'b0;
            if (s < NDIR) begin
                st = dirTab[s];
            end else begin
                st = {($urandom_range(0, 3) != 0) || (s == RESET_SLOT), randByte(), randByte(),
                      randByte(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            end
            applyStimulus(st[26], st[25:18], st[17:10], st[9:2], st[1], st[0]);
            if (s == RESET_SLOT) begin
                midSlotReset();
                atReq = 1'b1;
            end
        end
        for (int s = 0; s < 2; s++) begin
            waitReq();
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        waitReq();
        checkEn = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
